// File: rtl/regfile_wb_scheduler.sv
// Write-back arbiter and busy scoreboard for the 8x8 register file.
// Optional macro WB_BYPASS_EN adds forwarding of the in-flight write to decode.
module regfile_wb_scheduler #(
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int DW   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_addr,
  output logic            iss_stall,
  input  logic [AW-1:0]   rd1_addr,
  input  logic [AW-1:0]   rd2_addr,
  output logic            rd_stall,
  input  logic            a_valid,
  input  logic [AW-1:0]   a_addr,
  input  logic [DW-1:0]   a_data,
  output logic            a_ready,
  input  logic            m_valid,
  input  logic [AW-1:0]   m_addr,
  input  logic [DW-1:0]   m_data,
  output logic            m_ready,
  output logic            rf_wr_en,
  output logic [AW-1:0]   rf_wr_addr,
  output logic [DW-1:0]   rf_wr_data,
  output logic [NREG-1:0] busy,
  output logic [AW:0]     busy_cnt,
  output logic            err_spur
`ifdef WB_BYPASS_EN
  ,
  output logic            fwd1,
  output logic            fwd2,
  output logic [DW-1:0]   fwd_data
`endif
);

  typedef enum logic {GRANT_A = 1'b0, GRANT_M = 1'b1} grant_e;

  grant_e          last_grant_r, last_grant_nxt_s;
  logic [NREG-1:0] busy_r, busy_nxt_s;
  logic [AW:0]     busy_cnt_r;
  logic            rf_wr_en_r;
  logic [AW-1:0]   rf_wr_addr_r, wr_addr_nxt_s;
  logic [DW-1:0]   rf_wr_data_r, wr_data_nxt_s;
  logic            err_spur_r, err_nxt_s;
  logic            a_ready_s, m_ready_s, grant_s, iss_ok_s;
  logic            hit1_s, hit2_s;

  function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) begin
      c = c + {{AW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Round-robin grant: the requester that did not win last time wins a tie.
  always_comb begin
    a_ready_s        = a_valid & (~m_valid | (last_grant_r == GRANT_M));
    m_ready_s        = m_valid & (~a_valid | (last_grant_r == GRANT_A));
    grant_s          = a_ready_s | m_ready_s;
    last_grant_nxt_s = last_grant_r;
    wr_addr_nxt_s    = rf_wr_addr_r;
    wr_data_nxt_s    = rf_wr_data_r;
    if (a_ready_s) begin
      last_grant_nxt_s = GRANT_A;
      wr_addr_nxt_s    = a_addr;
      wr_data_nxt_s    = a_data;
    end else if (m_ready_s) begin
      last_grant_nxt_s = GRANT_M;
      wr_addr_nxt_s    = m_addr;
      wr_data_nxt_s    = m_data;
    end else begin
      last_grant_nxt_s = last_grant_r;
    end
  end

  // Scoreboard update; the issue set is applied last so it wins over a same-edge clear.
  always_comb begin
    iss_stall  = iss_valid & busy_r[iss_addr];
    iss_ok_s   = iss_valid & ~busy_r[iss_addr];
    busy_nxt_s = busy_r;
    err_nxt_s  = err_spur_r;
    if (grant_s) begin
      busy_nxt_s[wr_addr_nxt_s] = 1'b0;
      err_nxt_s = err_spur_r | ~busy_r[wr_addr_nxt_s];
    end else begin
      err_nxt_s = err_spur_r;
    end
    if (iss_ok_s) begin
      busy_nxt_s[iss_addr] = 1'b1;
    end else begin
      busy_nxt_s[iss_addr] = busy_nxt_s[iss_addr];
    end
  end

  // Read hazard detection against pending and in-flight writes.
  always_comb begin
    hit1_s = rf_wr_en_r & (rf_wr_addr_r == rd1_addr);
    hit2_s = rf_wr_en_r & (rf_wr_addr_r == rd2_addr);
`ifdef WB_BYPASS_EN
    rd_stall = busy_r[rd1_addr] | busy_r[rd2_addr];
    fwd1     = hit1_s;
    fwd2     = hit2_s;
    fwd_data = rf_wr_data_r;
`else
    rd_stall = busy_r[rd1_addr] | busy_r[rd2_addr] | hit1_s | hit2_s;
`endif
  end

  // State registers; reset drops any in-flight write and all pending entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_r <= GRANT_M;
      busy_r       <= '0;
      busy_cnt_r   <= '0;
      rf_wr_en_r   <= 1'b0;
      rf_wr_addr_r <= '0;
      rf_wr_data_r <= '0;
      err_spur_r   <= 1'b0;
    end else begin
      last_grant_r <= last_grant_nxt_s;
      busy_r       <= busy_nxt_s;
      busy_cnt_r   <= popcount(busy_nxt_s);
      rf_wr_en_r   <= grant_s;
      rf_wr_addr_r <= wr_addr_nxt_s;
      rf_wr_data_r <= wr_data_nxt_s;
      err_spur_r   <= err_nxt_s;
    end
  end

  assign a_ready    = a_ready_s;
  assign m_ready    = m_ready_s;
  assign rf_wr_en   = rf_wr_en_r;
  assign rf_wr_addr = rf_wr_addr_r;
  assign rf_wr_data = rf_wr_data_r;
  assign busy       = busy_r;
  assign busy_cnt   = busy_cnt_r;
  assign err_spur   = err_spur_r;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed table-driven bench for regfile_wb_scheduler, plus a reset-mid-operation sequence.
module tb_regfile_wb_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       iss_valid, iss_stall, rd_stall;
  logic [2:0] iss_addr, rd1_addr, rd2_addr;
  logic       a_valid, a_ready, m_valid, m_ready;
  logic [2:0] a_addr, m_addr;
  logic [7:0] a_data, m_data;
  logic       rf_wr_en;
  logic [2:0] rf_wr_addr;
  logic [7:0] rf_wr_data;
  logic [7:0] busy;
  logic [3:0] busy_cnt;
  logic       err_spur;
`ifdef WB_BYPASS_EN
  logic       fwd1, fwd2;
  logic [7:0] fwd_data;
`endif

  int tests = 0;
  int fails = 0;

  regfile_wb_scheduler dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_stall(iss_stall),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr), .rd_stall(rd_stall),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .busy(busy), .busy_cnt(busy_cnt), .err_spur(err_spur)
`ifdef WB_BYPASS_EN
    , .fwd1(fwd1), .fwd2(fwd2), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  // Inputs for one cycle, combinational expectations before the edge,
  // registered expectations after the edge.
  typedef struct {
    int iv, ia, r1, r2, av, aa, ad, mv, ma, md;
    int ar, mr, is, rs, rsb, fw1;
    int we, wa, wd, bz, cnt, err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int iv, ia, r1, r2, av, aa, ad, mv, ma, md,
                     input int ar, mr, is, rs, rsb, fw1,
                     input int we, wa, wd, bz, cnt, err);
    vec_t v;
    v.iv = iv; v.ia = ia; v.r1 = r1; v.r2 = r2; v.av = av; v.aa = aa; v.ad = ad;
    v.mv = mv; v.ma = ma; v.md = md;
    v.ar = ar; v.mr = mr; v.is = is; v.rs = rs; v.rsb = rsb; v.fw1 = fw1;
    v.we = we; v.wa = wa; v.wd = wd; v.bz = bz; v.cnt = cnt; v.err = err;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int iv, ia, r1, r2, av, aa, ad, mv, ma, md);
    iss_valid = iv[0]; iss_addr = ia[2:0]; rd1_addr = r1[2:0]; rd2_addr = r2[2:0];
    a_valid = av[0]; a_addr = aa[2:0]; a_data = ad[7:0];
    m_valid = mv[0]; m_addr = ma[2:0]; m_data = md[7:0];
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    //   iv ia r1 r2 av aa ad     mv ma md      ar mr is rs rsb fw1  we wa wd     busy   cnt err
    add(1, 3, 0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,    0, 0, 0,     'h08, 1, 0);
    add(0, 0, 0, 0, 1, 3, 'h5A,   0, 0, 0,      1, 0, 0, 0, 0, 0,    1, 3, 'h5A,  'h00, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,    0, 3, 'h5A,  'h02, 1, 0);
    add(1, 2, 0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,    0, 3, 'h5A,  'h06, 2, 0);
    add(1, 6, 0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,    0, 3, 'h5A,  'h46, 3, 0);
    add(1, 7, 0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,    0, 3, 'h5A,  'hC6, 4, 0);
    add(0, 0, 0, 0, 1, 1, 'h11,   1, 6, 'h66,   0, 1, 0, 0, 0, 0,    1, 6, 'h66,  'h86, 3, 0);
    add(0, 0, 0, 0, 1, 1, 'h11,   1, 7, 'h77,   1, 0, 0, 0, 0, 0,    1, 1, 'h11,  'h84, 2, 0);
    add(0, 0, 0, 0, 1, 2, 'h22,   1, 7, 'h77,   0, 1, 0, 0, 0, 0,    1, 7, 'h77,  'h04, 1, 0);
    add(0, 0, 0, 0, 1, 2, 'h22,   0, 0, 0,      1, 0, 0, 0, 0, 0,    1, 2, 'h22,  'h00, 0, 0);
    add(1, 5, 0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,    0, 2, 'h22,  'h20, 1, 0);
    add(1, 5, 0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 1, 0, 0, 0,    0, 2, 'h22,  'h20, 1, 0);
    add(0, 0, 0, 0, 1, 5, 'h55,   0, 0, 0,      1, 0, 0, 0, 0, 0,    1, 5, 'h55,  'h00, 0, 0);
    add(1, 2, 2, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,    0, 5, 'h55,  'h04, 1, 0);
    add(0, 0, 0, 2, 0, 0, 0,      0, 0, 0,      0, 0, 0, 1, 1, 0,    0, 5, 'h55,  'h04, 1, 0);
    add(0, 0, 2, 0, 1, 2, 'hA7,   0, 0, 0,      1, 0, 0, 1, 1, 0,    1, 2, 'hA7,  'h00, 0, 0);
    add(0, 0, 2, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 1, 0, 1,    0, 2, 'hA7,  'h00, 0, 0);
    add(0, 0, 0, 0, 1, 6, 'h66,   0, 0, 0,      1, 0, 0, 0, 0, 0,    1, 6, 'h66,  'h00, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,    0, 6, 'h66,  'h00, 0, 1);
    add(1, 4, 0, 0, 1, 4, 'h44,   0, 0, 0,      1, 0, 0, 0, 0, 0,    1, 4, 'h44,  'h10, 1, 1);
    add(1, 1, 0, 0, 1, 4, 'h45,   0, 0, 0,      1, 0, 0, 0, 0, 0,    1, 4, 'h45,  'h02, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0,      1, 1, 'h91,   0, 1, 0, 0, 0, 0,    1, 1, 'h91,  'h00, 0, 1);
    add(0, 0, 0, 0, 1, 3, 'h33,   1, 3, 'h34,   1, 0, 0, 0, 0, 0,    1, 3, 'h33,  'h00, 0, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 'h00);
    chk("reset_cnt", busy_cnt, 0);
    chk("reset_wr_en", rf_wr_en, 0);
    chk("reset_wr_addr", rf_wr_addr, 0);
    chk("reset_wr_data", rf_wr_data, 0);
    chk("reset_err", err_spur, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].iv, vq[i].ia, vq[i].r1, vq[i].r2, vq[i].av, vq[i].aa, vq[i].ad,
            vq[i].mv, vq[i].ma, vq[i].md);
      #1;
      chk($sformatf("v%0d_a_ready", i), a_ready, vq[i].ar);
      chk($sformatf("v%0d_m_ready", i), m_ready, vq[i].mr);
      chk($sformatf("v%0d_iss_stall", i), iss_stall, vq[i].is);
`ifdef WB_BYPASS_EN
      chk($sformatf("v%0d_rd_stall", i), rd_stall, vq[i].rsb);
      chk($sformatf("v%0d_fwd1", i), fwd1, vq[i].fw1);
      if (vq[i].fw1 != 0) chk($sformatf("v%0d_fwd_data", i), fwd_data, vq[i].wd);
`else
      chk($sformatf("v%0d_rd_stall", i), rd_stall, vq[i].rs);
`endif
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wr_en", i), rf_wr_en, vq[i].we);
      chk($sformatf("v%0d_wr_addr", i), rf_wr_addr, vq[i].wa);
      chk($sformatf("v%0d_wr_data", i), rf_wr_data, vq[i].wd);
      chk($sformatf("v%0d_busy", i), busy, vq[i].bz);
      chk($sformatf("v%0d_busy_cnt", i), busy_cnt, vq[i].cnt);
      chk($sformatf("v%0d_err_spur", i), err_spur, vq[i].err);
    end

    // Fill the scoreboard, then reset with a write in flight.
    for (int r = 0; r < 7; r++) begin
      @(negedge clk);
      drive(1, r, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    drive(1, 7, 0, 0, 1, 7, 'h77, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("full_busy", busy, 'hFF);
    chk("full_cnt", busy_cnt, 8);
    chk("full_wr_en", rf_wr_en, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 'h00);
    chk("midrst_cnt", busy_cnt, 0);
    chk("midrst_wr_en", rf_wr_en, 0);
    chk("midrst_err", err_spur, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 1, 1, 'hC1, 1, 2, 'hC2);
    #1;
    chk("post_rst_a_ready", a_ready, 1);
    chk("post_rst_m_ready", m_ready, 0);
    @(posedge clk);
    #1;
    chk("post_rst_wr_en", rf_wr_en, 1);
    chk("post_rst_wr_addr", rf_wr_addr, 1);
    chk("post_rst_wr_data", rf_wr_data, 'hC1);
    chk("post_rst_err", err_spur, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
